instr_fetch_unit: RTL and testbench

- Fetch stage of the 24-bit CPU. Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a 2-entry FIFO.
- Presents them to the decode stage with a valid/ready handshake; `id_opcode` drives the control unit's `OPCODE` input directly.
- Supports branch redirect with flush of buffered and in-flight fetches.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side handshakes.
// The master modport is the fetch unit; the slave modport is memory, branch logic and decode.
interface instr_fetch_unit_if #(
  parameter int PC_W = 24
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [23:0]     imem_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [23:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic [3:0]      id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, single-outstanding instruction memory request,
// 2-entry instruction FIFO toward decode, and branch redirect with in-flight kill.
module instr_fetch_unit #(
  parameter int              PC_W     = 24,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drain_addr_q, drain_addr_d;
  logic [23:0]     instr_q [2];
  logic [23:0]     instr_d [2];
  logic [PC_W-1:0] epc_q [2];
  logic [PC_W-1:0] epc_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            push_s;
  logic            pop_s;

  // Next-state, PC and FIFO bookkeeping; a redirect overrides any push.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    epc_d        = epc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    push_s       = 1'b0;
    pop_s        = (count_q != 2'd0) && bus.id_ready;

    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        // If the killed fetch completes in this very cycle there is nothing left to drain.
        ST_DRAIN: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      push_s = (state_q == ST_REQ) && bus.imem_ack;
      if (push_s) begin
        instr_d[wr_ptr_q] = bus.imem_rdata;
        epc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d          = ~wr_ptr_q;
        pc_d              = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
      case (state_q)
        ST_IDLE: begin
          if (count_q < 2'd2) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.imem_ack && (count_d >= 2'd2)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, PC and FIFO registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= {PC_W{1'b0}};
      instr_q[0]   <= 24'd0;
      instr_q[1]   <= 24'd0;
      epc_q[0]     <= {PC_W{1'b0}};
      epc_q[1]     <= {PC_W{1'b0}};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      epc_q        <= epc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_req  = (state_q != ST_IDLE);
  assign bus.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign bus.id_valid  = (count_q != 2'd0);
  assign bus.id_instr  = instr_q[rd_ptr_q];
  assign bus.id_pc     = epc_q[rd_ptr_q];
  assign bus.id_opcode = instr_q[rd_ptr_q][23:20];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: a 24-bit instance with a
// variable-latency memory and a 4-bit-PC instance with zero-wait memory for wrap.
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;
  logic rst_b;
  int   n_checks;
  int   n_pass;
  int   lat_a;
  int   cnt_a;

  instr_fetch_unit_if #(.PC_W(24)) bus_a ();
  instr_fetch_unit_if #(.PC_W(4))  bus_b ();

  instr_fetch_unit #(.PC_W(24), .RESET_PC(24'h000000)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  instr_fetch_unit #(.PC_W(4), .RESET_PC(4'hC)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A acks lat_a cycles after the request rises; memory B is zero-wait.
  always @(posedge clk) begin
    if (!bus_a.imem_req || bus_a.imem_ack) cnt_a <= 0;
    else cnt_a <= cnt_a + 1;
  end
  assign bus_a.imem_ack   = bus_a.imem_req && (cnt_a >= lat_a);
  assign bus_a.imem_rdata = {4'b0110, bus_a.imem_addr[19:0]};
  assign bus_b.imem_ack   = bus_b.imem_req;
  assign bus_b.imem_rdata = {4'b0110, 16'h0000, bus_b.imem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a.redirect = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lat_a = 0;
    bus_a.id_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus_a.imem_req !== 1'b0) $display("FAIL reset_req: got %0h want 0", bus_a.imem_req);
    else n_pass++;
    n_checks++;
    if (bus_a.id_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", bus_a.id_valid);
    else n_pass++;
    n_checks++;
    if ({bus_a.id_instr, bus_a.id_pc} !== 48'h0) $display("FAIL reset_instr_pc: got %0h/%0h want 0/0", bus_a.id_instr, bus_a.id_pc);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid} !== {1'b1, 24'h000000, 1'b0})
      $display("FAIL stream_e1: got req=%0h addr=%0h valid=%0h want 1/0/0", bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus_a.id_valid, bus_a.id_pc, bus_a.id_instr, bus_a.id_opcode, bus_a.imem_addr} !== {1'b1, 24'h000000, 24'h600000, 4'b0110, 24'h000001})
      $display("FAIL stream_e2: got v=%0h pc=%0h instr=%0h op=%0h addr=%0h want 1/0/600000/6/1",
               bus_a.id_valid, bus_a.id_pc, bus_a.id_instr, bus_a.id_opcode, bus_a.imem_addr);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if ({bus_a.id_valid, bus_a.id_pc, bus_a.id_opcode} !== {1'b1, 24'(k), 4'b0110})
        $display("FAIL stream_seq: got v=%0h pc=%0h op=%0h want 1/%0h/6", bus_a.id_valid, bus_a.id_pc, bus_a.id_opcode, k);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] got [$];
    lat_a = 0;
    bus_a.id_ready = 1'b1;
    do_reset();
    tick();
    tick();
    bus_a.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({bus_a.imem_req, bus_a.id_valid, bus_a.id_pc} !== {1'b0, 1'b1, 24'h000000})
        $display("FAIL bp_hold: got req=%0h v=%0h pc=%0h want 0/1/0", bus_a.imem_req, bus_a.id_valid, bus_a.id_pc);
      else n_pass++;
    end
    bus_a.id_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (bus_a.id_valid) got.push_back(bus_a.id_pc);
      tick();
    end
    n_checks++;
    if (got.size() < 3) $display("FAIL bp_count: got %0d deliveries want at least 3", got.size());
    else n_pass++;
    for (int k = 0; k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== 24'(k)) $display("FAIL bp_order: got pc=%0h want %0h", got[k], k);
      else n_pass++;
    end
  endtask

  task automatic test_wait_state();
    lat_a = 3;
    bus_a.id_ready = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if ({bus_a.imem_req, bus_a.imem_addr} !== {1'b1, 24'(i / 4)})
        $display("FAIL ws_addr: got req=%0h addr=%0h want 1/%0h", bus_a.imem_req, bus_a.imem_addr, i / 4);
      else n_pass++;
      n_checks++;
      if (i >= 4 && (i % 4) == 0) begin
        if ({bus_a.id_valid, bus_a.id_pc} !== {1'b1, 24'(i / 4 - 1)})
          $display("FAIL ws_valid: got v=%0h pc=%0h want 1/%0h", bus_a.id_valid, bus_a.id_pc, i / 4 - 1);
        else n_pass++;
      end else begin
        if (bus_a.id_valid !== 1'b0) $display("FAIL ws_gap: got v=%0h want 0", bus_a.id_valid);
        else n_pass++;
      end
      tick();
    end
    lat_a = 0;
  endtask

  task automatic test_redirect_buffered();
    lat_a = 0;
    bus_a.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    n_checks++;
    if ({bus_a.imem_req, bus_a.id_valid, bus_a.id_pc} !== {1'b0, 1'b1, 24'h000000})
      $display("FAIL rb_full: got req=%0h v=%0h pc=%0h want 0/1/0", bus_a.imem_req, bus_a.id_valid, bus_a.id_pc);
    else n_pass++;
    bus_a.redirect = 1'b1;
    bus_a.redirect_pc = 24'h000040;
    tick();
    bus_a.redirect = 1'b0;
    n_checks++;
    if ({bus_a.id_valid, bus_a.imem_req, bus_a.imem_addr} !== {1'b0, 1'b1, 24'h000040})
      $display("FAIL rb_flush: got v=%0h req=%0h addr=%0h want 0/1/40", bus_a.id_valid, bus_a.imem_req, bus_a.imem_addr);
    else n_pass++;
    bus_a.id_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus_a.id_valid, bus_a.id_pc, bus_a.id_instr} !== {1'b1, 24'h000040, 24'h600040})
      $display("FAIL rb_first: got v=%0h pc=%0h instr=%0h want 1/40/600040", bus_a.id_valid, bus_a.id_pc, bus_a.id_instr);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus_a.id_valid, bus_a.id_pc} !== {1'b1, 24'h000041})
      $display("FAIL rb_second: got v=%0h pc=%0h want 1/41", bus_a.id_valid, bus_a.id_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_outstanding();
    lat_a = 2;
    bus_a.id_ready = 1'b1;
    do_reset();
    tick();
    bus_a.redirect = 1'b1;
    bus_a.redirect_pc = 24'h000100;
    tick();
    bus_a.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid} !== {1'b1, 24'h000000, 1'b0})
        $display("FAIL ro_drain: got req=%0h addr=%0h v=%0h want 1/0/0", bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid} !== {1'b1, 24'h000100, 1'b0})
        $display("FAIL ro_refetch: got req=%0h addr=%0h v=%0h want 1/100/0", bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({bus_a.id_valid, bus_a.id_pc, bus_a.id_instr} !== {1'b1, 24'h000100, 24'h600100})
      $display("FAIL ro_first: got v=%0h pc=%0h instr=%0h want 1/100/600100", bus_a.id_valid, bus_a.id_pc, bus_a.id_instr);
    else n_pass++;
    // Redirect landing on the same cycle as an ack drops that data.
    lat_a = 0;
    do_reset();
    tick();
    tick();
    bus_a.redirect = 1'b1;
    bus_a.redirect_pc = 24'h000100;
    tick();
    bus_a.redirect = 1'b0;
    n_checks++;
    if ({bus_a.id_valid, bus_a.imem_req, bus_a.imem_addr} !== {1'b0, 1'b1, 24'h000100})
      $display("FAIL ra_drop: got v=%0h req=%0h addr=%0h want 0/1/100", bus_a.id_valid, bus_a.imem_req, bus_a.imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus_a.id_valid, bus_a.id_pc} !== {1'b1, 24'h000100})
      $display("FAIL ra_first: got v=%0h pc=%0h want 1/100", bus_a.id_valid, bus_a.id_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] e;
    rst_b = 1'b1;
    tick();
    tick();
    e = 4'hC;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({bus_b.id_valid, bus_b.id_pc} !== {1'b1, e})
        $display("FAIL wrap_seq: got v=%0h pc=%0h want 1/%0h", bus_b.id_valid, bus_b.id_pc, e);
      else n_pass++;
      e = e + 4'd1;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    lat_a = 3;
    bus_a.id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if ({bus_a.imem_req, bus_a.imem_addr} !== {1'b1, 24'h000001})
      $display("FAIL rm_pre: got req=%0h addr=%0h want 1/1", bus_a.imem_req, bus_a.imem_addr);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({bus_a.imem_req, bus_a.id_valid, bus_a.imem_addr} !== {1'b0, 1'b0, 24'h000000})
      $display("FAIL rm_reset: got req=%0h v=%0h addr=%0h want 0/0/0", bus_a.imem_req, bus_a.id_valid, bus_a.imem_addr);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus_a.imem_req, bus_a.imem_addr} !== {1'b1, 24'h000000})
      $display("FAIL rm_restart: got req=%0h addr=%0h want 1/0", bus_a.imem_req, bus_a.imem_addr);
    else n_pass++;
    lat_a = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    lat_a = 0;
    rst_n = 1'b0;
    rst_b = 1'b0;
    bus_a.redirect = 1'b0;
    bus_a.redirect_pc = 24'h000000;
    bus_a.id_ready = 1'b1;
    bus_b.redirect = 1'b0;
    bus_b.redirect_pc = 4'h0;
    bus_b.id_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_wait_state();
    test_redirect_buffered();
    test_redirect_outstanding();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
